// File: rtl/hour_day_counter.sv
// hour_day_counter
// Hour-and-day stage of the digital clock chain. Each rising edge of clk_h_1
// is one hour. Keeps a 24-hour binary hour count and a day-of-week index, and
// produces a one-hour day carry on every 23->0 wrap. The hour is shown on two
// 7-segment digits in either 24-hour or 12-hour form, with an optional PM dot.
//
// Ports:
//   clk_h_1      in   hour tick clock
//   rst          in   asynchronous active-high reset
//   mode_12h     in   0 = 24-hour display, 1 = 12-hour display (display only)
//   hold         in   1 = hour does not advance on this edge
//   load         in   1 = load load_hour on this edge (wins over hold)
//   load_hour    in   hour to load, 0..23; larger values are ignored
//   hour_bin     out  registered hour, 24-hour binary
//   pm           out  1 when hour_bin >= 12, whatever the display mode
//   seg_data_h1  out  ones digit pattern {dp,g,f,e,d,c,b,a}, active-high
//   seg_data_h10 out  tens digit pattern, same format
//   day_carry    out  registered, high for one hour after a 23->0 wrap
//   day_idx      out  registered day-of-week index, 0..DAYS-1
module hour_day_counter #(
  parameter int DAYS       = 7,
  parameter int DAY_W      = 3,
  parameter int BLANK_LEAD = 0,
  parameter int DP_PM      = 1
) (
  input  logic             clk_h_1,
  input  logic             rst,
  input  logic             mode_12h,
  input  logic             hold,
  input  logic             load,
  input  logic [4:0]       load_hour,
  output logic [4:0]       hour_bin,
  output logic             pm,
  output logic [7:0]       seg_data_h1,
  output logic [7:0]       seg_data_h10,
  output logic             day_carry,
  output logic [DAY_W-1:0] day_idx
);

  localparam logic [DAY_W-1:0] DAY_LAST = DAY_W'(DAYS - 1);
  localparam logic [DAY_W-1:0] DAY_ZERO = DAY_W'(0);
  localparam logic [DAY_W-1:0] DAY_ONE  = DAY_W'(1);

  // 7-segment pattern for one decimal digit; anything out of range is blank.
  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = 8'h3F;
      4'd1:    pat = 8'h06;
      4'd2:    pat = 8'h5B;
      4'd3:    pat = 8'h4F;
      4'd4:    pat = 8'h66;
      4'd5:    pat = 8'h6D;
      4'd6:    pat = 8'h7D;
      4'd7:    pat = 8'h07;
      4'd8:    pat = 8'h7F;
      4'd9:    pat = 8'h6F;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  logic [4:0]       hour_r;
  logic [DAY_W-1:0] day_r;
  logic             carry_r;

  logic [4:0]       hour_nx_s;
  logic [DAY_W-1:0] day_nx_s;
  logic             carry_nx_s;

  logic [4:0]       disp_s;
  logic [1:0]       tens_s;
  logic [3:0]       ones_s;
  logic             dp_s;

  // Next-state decision for one hour edge: load beats hold beats advance.
  // The carry is a one-hour pulse, so it defaults low on every edge.
  always_comb begin
    hour_nx_s  = hour_r;
    day_nx_s   = day_r;
    carry_nx_s = 1'b0;
    if (load) begin
      if (load_hour <= 5'd23) begin
        hour_nx_s = load_hour;
      end else begin
        hour_nx_s = hour_r;
      end
    end else if (hold) begin
      hour_nx_s = hour_r;
    end else if (hour_r == 5'd23) begin
      // Only a real advance past 23 is a day wrap; a load of 0 is not.
      hour_nx_s  = 5'd0;
      carry_nx_s = 1'b1;
      if (day_r == DAY_LAST) begin
        day_nx_s = DAY_ZERO;
      end else begin
        day_nx_s = day_r + DAY_ONE;
      end
    end else begin
      hour_nx_s = hour_r + 5'd1;
    end
  end

  // Hour, day and carry registers with asynchronous clear.
  always_ff @(posedge clk_h_1 or posedge rst) begin
    if (rst) begin
      hour_r  <= 5'd0;
      day_r   <= DAY_ZERO;
      carry_r <= 1'b0;
    end else begin
      hour_r  <= hour_nx_s;
      day_r   <= day_nx_s;
      carry_r <= carry_nx_s;
    end
  end

  // Displayed hour: 12-hour mode maps 0 and 12 to 12 and 13..23 to 1..11.
  always_comb begin
    disp_s = hour_r;
    if (!mode_12h) begin
      disp_s = hour_r;
    end else if ((hour_r == 5'd0) || (hour_r == 5'd12)) begin
      disp_s = 5'd12;
    end else if (hour_r > 5'd12) begin
      disp_s = hour_r - 5'd12;
    end else begin
      disp_s = hour_r;
    end
  end

  // BCD split by compare and subtract; the display value never exceeds 23.
  always_comb begin
    tens_s = 2'd0;
    ones_s = 4'd0;
    if (disp_s >= 5'd20) begin
      tens_s = 2'd2;
      ones_s = 4'(disp_s - 5'd20);
    end else if (disp_s >= 5'd10) begin
      tens_s = 2'd1;
      ones_s = 4'(disp_s - 5'd10);
    end else begin
      tens_s = 2'd0;
      ones_s = disp_s[3:0];
    end
  end

  // Digit patterns; the PM dot only appears in 12-hour mode.
  always_comb begin
    dp_s        = (DP_PM != 0) && mode_12h && pm;
    seg_data_h1 = seg_pattern(ones_s) | {dp_s, 7'b000_0000};
    if ((BLANK_LEAD != 0) && (tens_s == 2'd0)) begin
      seg_data_h10 = 8'h00;
    end else begin
      seg_data_h10 = seg_pattern({2'b00, tens_s});
    end
  end

  assign pm        = (hour_r >= 5'd12);
  assign hour_bin  = hour_r;
  assign day_idx   = day_r;
  assign day_carry = carry_r;

endmodule

// File: tb/tb_hour_day_counter.sv
// Scoreboard bench for hour_day_counter. Two instances share all inputs:
// dut_a uses the default parameters (7 days, no blanking, PM dot), dut_b uses
// 5 days, leading-zero blanking and no PM dot. Stimulus pushes the expected
// state after every edge; a monitor pops and compares on each falling edge.
module tb_hour_day_counter;

  logic       clk_h_1 = 1'b0;
  logic       rst     = 1'b1;
  logic       mode_12h = 1'b0;
  logic       hold = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hour = 5'd0;

  logic [4:0] hour_a, hour_b;
  logic       pm_a, pm_b;
  logic [7:0] h1_a, h10_a, h1_b, h10_b;
  logic       carry_a, carry_b;
  logic [2:0] day_a, day_b;

  hour_day_counter #(.DAYS(7), .DAY_W(3), .BLANK_LEAD(0), .DP_PM(1)) dut_a (
    .clk_h_1(clk_h_1), .rst(rst), .mode_12h(mode_12h), .hold(hold),
    .load(load), .load_hour(load_hour), .hour_bin(hour_a), .pm(pm_a),
    .seg_data_h1(h1_a), .seg_data_h10(h10_a), .day_carry(carry_a),
    .day_idx(day_a)
  );

  hour_day_counter #(.DAYS(5), .DAY_W(3), .BLANK_LEAD(1), .DP_PM(0)) dut_b (
    .clk_h_1(clk_h_1), .rst(rst), .mode_12h(mode_12h), .hold(hold),
    .load(load), .load_hour(load_hour), .hour_bin(hour_b), .pm(pm_b),
    .seg_data_h1(h1_b), .seg_data_h10(h10_b), .day_carry(carry_b),
    .day_idx(day_b)
  );

  always #5 clk_h_1 = ~clk_h_1;

  typedef struct {
    string name;
    int    hour;
    int    carry;
    int    pm;
    int    day7;
    int    day5;
    int    h10a;
    int    h1a;
    int    h10b;
    int    h1b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Bench model state
  int m_hour = 0;
  int m_day7 = 0;
  int m_day5 = 0;
  int m_carry = 0;

  // Hand-written 12-hour display value for each 24-hour value.
  int t12[24] = '{12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                  12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

  function automatic int seg_of(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h at t=%0t", nm, fld, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hour = 0; m_day7 = 0; m_day5 = 0; m_carry = 0;
  endtask

  task automatic model_edge(input logic ld, input logic hd, input int lh);
    if (ld) begin
      if (lh <= 23) m_hour = lh;
      m_carry = 0;
    end else if (hd) begin
      m_carry = 0;
    end else if (m_hour == 23) begin
      m_hour  = 0;
      m_carry = 1;
      m_day7  = (m_day7 == 6) ? 0 : m_day7 + 1;
      m_day5  = (m_day5 == 4) ? 0 : m_day5 + 1;
    end else begin
      m_hour  = m_hour + 1;
      m_carry = 0;
    end
  endtask

  task automatic push_model(input string nm);
    exp_t e;
    int disp, tens, ones;
    disp = mode_12h ? t12[m_hour] : m_hour;
    tens = disp / 10;
    ones = disp % 10;
    e.name  = nm;
    e.hour  = m_hour;
    e.carry = m_carry;
    e.pm    = (m_hour >= 12) ? 1 : 0;
    e.day7  = m_day7;
    e.day5  = m_day5;
    e.h10a  = seg_of(tens);
    e.h1a   = seg_of(ones) | ((mode_12h && m_hour >= 12) ? 8'h80 : 8'h00);
    e.h10b  = (tens == 0) ? 8'h00 : seg_of(tens);
    e.h1b   = seg_of(ones);
    exp_q.push_back(e);
  endtask

  task automatic tick(input string nm, input logic ld, input logic hd, input int lh);
    load = ld;
    hold = hd;
    load_hour = 5'(lh);
    @(posedge clk_h_1);
    #1;
    model_edge(ld, hd, lh);
    push_model(nm);
  endtask

  // Hold edge whose display expectations are written out by hand.
  task automatic hold_check(input string nm, input int h10a, input int h1a,
                            input int h10b, input int h1b);
    exp_t e;
    tick(nm, 1'b0, 1'b1, 0);
    e = exp_q.pop_back();
    e.h10a = h10a; e.h1a = h1a; e.h10b = h10b; e.h1b = h1b;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the queue head on falling edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_h_1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "hour_bin", hour_a, e.hour);
        chk(e.name, "day_carry", carry_a, e.carry);
        chk(e.name, "pm", pm_a, e.pm);
        chk(e.name, "day_idx7", day_a, e.day7);
        chk(e.name, "seg_h10", h10_a, e.h10a);
        chk(e.name, "seg_h1", h1_a, e.h1a);
        chk(e.name, "hour_bin_b", hour_b, e.hour);
        chk(e.name, "day_idx5", day_b, e.day5);
        chk(e.name, "seg_h10_b", h10_b, e.h10b);
        chk(e.name, "seg_h1_b", h1_b, e.h1b);
      end
    end
  end

  initial begin
    int guard;
    // Reset held through the first edge
    @(posedge clk_h_1);
    #1;
    model_reset();
    push_model("reset");
    @(negedge clk_h_1);
    #1;
    rst = 1'b0;

    // 24-hour count up to 23
    for (int i = 0; i < 23; i++) tick("count24", 1'b0, 1'b0, 0);
    hold_check("h23_24h", 8'h5B, 8'h4F, 8'h5B, 8'h4F);
    tick("wrap", 1'b0, 1'b0, 0);
    tick("after_wrap", 1'b0, 1'b0, 0);

    // 12-hour sweep through a full day
    mode_12h = 1'b1;
    for (int i = 0; i < 24; i++) tick("sweep12", 1'b0, 1'b0, 0);
    tick("load0", 1'b1, 1'b0, 0);
    hold_check("h0_12h", 8'h06, 8'h5B, 8'h06, 8'h5B);
    tick("load13", 1'b1, 1'b0, 13);
    hold_check("h13_12h", 8'h3F, 8'h86, 8'h00, 8'h06);
    tick("load12", 1'b1, 1'b0, 12);
    hold_check("h12_12h", 8'h06, 8'hDB, 8'h06, 8'h5B);

    // Load behaviour
    tick("load23", 1'b1, 1'b0, 23);
    tick("wrap_after_load", 1'b0, 1'b0, 0);
    tick("carry_clear", 1'b0, 1'b0, 0);
    tick("load24_ignored", 1'b1, 1'b0, 24);
    tick("load31_ignored", 1'b1, 1'b0, 31);
    tick("load_beats_hold", 1'b1, 1'b1, 5);

    // Hold at 23, then release
    tick("load23_hold", 1'b1, 1'b0, 23);
    for (int i = 0; i < 5; i++) tick("hold23", 1'b0, 1'b1, 0);
    tick("release_wrap", 1'b0, 1'b0, 0);
    tick("hold_drops_carry", 1'b0, 1'b1, 0);

    // Load of 0 at hour 23 is not a wrap
    tick("load23_b", 1'b1, 1'b0, 23);
    tick("load0_at23", 1'b1, 1'b0, 0);

    // Wrap with a load on the following edge still clears the carry
    tick("load23_c", 1'b1, 1'b0, 23);
    tick("wrap_c", 1'b0, 1'b0, 0);
    tick("load_drops_carry", 1'b1, 1'b0, 7);

    // Reach hour 17 on day 3, then pulse reset mid-cycle
    guard = 0;
    while (m_day7 != 3 && guard < 8) begin
      tick("seek_load23", 1'b1, 1'b0, 23);
      tick("seek_wrap", 1'b0, 1'b0, 0);
      guard++;
    end
    tick("load17", 1'b1, 1'b0, 17);
    load = 1'b0;
    hold = 1'b0;
    @(negedge clk_h_1);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk_h_1);
    #1;
    model_reset();
    model_edge(1'b0, 1'b0, 0);
    push_model("resume_after_rst");

    // Full week in 24-hour mode: both day counters wrap
    mode_12h = 1'b0;
    for (int i = 0; i < 7 * 24; i++) tick("week", 1'b0, 1'b0, 0);

    load = 1'b0;
    hold = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk_h_1);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
